aidan_mcnay_div_arbiter: RTL

Round-robin arbiter and sequencer that shares one `aidan_mcnay_combo_div` iterative divider between two requesters in the prime-detection design, e.g. two trial-division engines working on different candidates. It accepts one request at a time over val/rdy, registers the operands, drives the divider handshake, captures the result and returns it to the requester that issued it. Only one transaction is in flight at any time.

---
 rtl/aidan_mcnay_div_arbiter_pkg.sv | 25 ++
 rtl/aidan_mcnay_rr_arbiter2.sv | 30 +++
 rtl/aidan_mcnay_div_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aidan_mcnay_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aidan_mcnay_div_arbiter_pkg
//  Description : Shared constants for the divider arbiter: FSM state
//                encodings, requester count and a small one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aidan_mcnay_div_arbiter_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Number of requesters sharing the divider
    localparam int unsigned c_NUM_REQ = 2;

    // Turn a requester index into its one-hot strobe vector
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aidan_mcnay_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : aidan_mcnay_rr_arbiter2
//  Description : Combinational two-way grant. A lone valid requester always
//                wins; when both are valid the priority pointer decides.
//  Ports       : i_req_val   - request valid per requester
//                i_prio      - requester favoured on contention
//                o_grant     - one-hot grant (all zero when nobody requests)
//                o_grant_idx - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module aidan_mcnay_rr_arbiter2
    import aidan_mcnay_div_arbiter_pkg::*;
(
    input  logic [1:0] i_req_val,
    input  logic       i_prio,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);

    logic w_both;

    assign w_both = &i_req_val;

    // With a single requester, bit 1 alone tells which one it is
    assign o_grant_idx = w_both ? i_prio : i_req_val[1];
    assign o_grant     = (|i_req_val) ? onehot2(o_grant_idx) : 2'b00;

endmodule
`default_nettype wire

// File: rtl/aidan_mcnay_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : aidan_mcnay_div_arbiter
//  Description : Round-robin sequencer sharing one iterative divider between
//                two requesters. One transaction in flight at a time:
//                accept -> issue to divider -> wait result -> respond.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                req_val/req_rdy       - per-requester request handshake
//                req{0,1}_opa/opb      - per-requester dividend / divisor
//                resp_val/resp_rdy     - per-requester response handshake
//                resp_result           - registered result (shared)
//                owner, busy           - current owner index, not-idle flag
//                div_opa/div_opb       - registered operands to the divider
//                div_istream_val/rdy   - divider input handshake
//                div_ostream_val/rdy   - divider output handshake
//                div_result            - divider result
//  Revision    : 1.0 - initial release
// ============================================================================
module aidan_mcnay_div_arbiter
    import aidan_mcnay_div_arbiter_pkg::*;
#(
    parameter int nbits = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [c_NUM_REQ-1:0] req_val,
    output logic [c_NUM_REQ-1:0] req_rdy,
    input  logic [nbits-1:0]     req0_opa,
    input  logic [nbits-1:0]     req0_opb,
    input  logic [nbits-1:0]     req1_opa,
    input  logic [nbits-1:0]     req1_opb,
    output logic [c_NUM_REQ-1:0] resp_val,
    input  logic [c_NUM_REQ-1:0] resp_rdy,
    output logic [nbits-1:0]     resp_result,
    output logic                 owner,
    output logic                 busy,
    output logic [nbits-1:0]     div_opa,
    output logic [nbits-1:0]     div_opb,
    output logic                 div_istream_val,
    input  logic                 div_istream_rdy,
    input  logic                 div_ostream_val,
    output logic                 div_ostream_rdy,
    input  logic [nbits-1:0]     div_result
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_prio;
    logic             r_owner;
    logic [nbits-1:0] r_div_opa;
    logic [nbits-1:0] r_div_opb;
    logic [nbits-1:0] r_resp_result;

    logic [1:0]       w_grant;
    logic             w_grant_idx;
    logic             w_idle;
    logic             w_accept;
    logic             w_capture;
    logic             w_resp_fire;

    aidan_mcnay_rr_arbiter2 u_rr_arb (
        .i_req_val   (req_val),
        .i_prio      (r_prio),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_idle      = (r_state == c_ST_IDLE);
    // Any valid request in IDLE is granted, so the grant handshake fires
    assign w_accept    = w_idle && (|req_val);
    assign w_capture   = (r_state == c_ST_WAIT) && div_ostream_val;
    // Only the owner's resp_rdy matters; the other requester is ignored
    assign w_resp_fire = (r_state == c_ST_RESP) && resp_rdy[r_owner];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept)        w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (div_istream_rdy) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (div_ostream_val) w_state_nxt = c_ST_RESP;
            c_ST_RESP:  if (w_resp_fire)     w_state_nxt = c_ST_IDLE;
            default:                         w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_prio        <= 1'b0;
            r_owner       <= 1'b0;
            r_div_opa     <= '0;
            r_div_opb     <= '0;
            r_resp_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner   <= w_grant_idx;
                r_div_opa <= w_grant_idx ? req1_opa : req0_opa;
                r_div_opb <= w_grant_idx ? req1_opb : req0_opb;
            end
            if (w_capture) begin
                r_resp_result <= div_result;
            end
            // Pointer rotates only on a completed response, never on abort
            if (w_resp_fire) begin
                r_prio <= ~r_owner;
            end
        end
    end

    // req_rdy is the only output with a combinational path from inputs
    assign req_rdy         = w_idle ? w_grant : 2'b00;
    assign div_istream_val = (r_state == c_ST_ISSUE);
    assign div_ostream_rdy = (r_state == c_ST_WAIT);
    assign resp_val        = (r_state == c_ST_RESP) ? onehot2(r_owner) : 2'b00;
    assign busy            = !w_idle;
    assign owner           = r_owner;
    assign div_opa         = r_div_opa;
    assign div_opb         = r_div_opb;
    assign resp_result     = r_resp_result;

endmodule
`default_nettype wire
